// File: rtl/set_job_arbiter.sv
// Round-robin job arbiter that shares one SET candidate-counting engine between NREQ requesters.
// Optional abort of stalled engine jobs is enabled by defining SET_ARB_TIMEOUT_EN.
module set_job_arbiter #(
   parameter int unsigned NREQ        = 4,
   parameter int unsigned IDW         = 2,
   parameter int unsigned TIMEOUT_CYC = 80
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [24*NREQ-1:0]   req_central,
   input  logic [12*NREQ-1:0]   req_radius,
   input  logic [2*NREQ-1:0]    req_mode,
   output logic                 set_en,
   output logic [23:0]          set_central,
   output logic [11:0]          set_radius,
   output logic [1:0]           set_mode,
   input  logic                 set_busy,
   input  logic                 set_valid,
   input  logic [7:0]           set_candidate,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [7:0]           rsp_candidate,
   output logic                 rsp_err
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e         state;
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] grant_idx;
   logic           grant_found;
   logic [31:0]    cand_idx;

   // Search starts one past the previous winner so every requester gets a turn.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand_idx    = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand_idx = (32'(last_grant) + k) % NREQ;
         if (!grant_found && req_valid[cand_idx[IDW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst && (state == StIdle) && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign set_en = rst && (state == StIssue) && !set_busy;

`ifdef SET_ARB_TIMEOUT_EN
   logic [7:0] wait_cnt;
`else
   logic [31:0] unused_timeout_cyc;
   assign unused_timeout_cyc = TIMEOUT_CYC;
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= StIdle;
         last_grant    <= IDW'(NREQ - 1);
         set_central   <= '0;
         set_radius    <= '0;
         set_mode      <= '0;
         rsp_valid     <= 1'b0;
         rsp_id        <= '0;
         rsp_candidate <= '0;
`ifdef SET_ARB_TIMEOUT_EN
         rsp_err       <= 1'b0;
         wait_cnt      <= '0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               if (grant_found) begin
                  set_central <= req_central[24*grant_idx +: 24];
                  set_radius  <= req_radius[12*grant_idx +: 12];
                  set_mode    <= req_mode[2*grant_idx +: 2];
                  rsp_id      <= grant_idx;
                  last_grant  <= grant_idx;
                  state       <= StIssue;
               end
            end
            StIssue: begin
               if (!set_busy) begin
                  state <= StWait;
`ifdef SET_ARB_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end
            end
            StWait: begin
               // A real result beats the timeout even on the terminal cycle.
               if (set_valid) begin
                  rsp_candidate <= set_candidate;
                  rsp_valid     <= 1'b1;
                  state         <= StResp;
`ifdef SET_ARB_TIMEOUT_EN
                  rsp_err       <= 1'b0;
               end else if (wait_cnt == 8'(TIMEOUT_CYC - 1)) begin
                  rsp_candidate <= '0;
                  rsp_err       <= 1'b1;
                  rsp_valid     <= 1'b1;
                  state         <= StResp;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
`endif
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_set_job_arbiter.sv
// Directed bench for set_job_arbiter; the bench itself plays the SET engine.
module tb_set_job_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned IDW  = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [24*NREQ-1:0] req_central = '0;
   logic [12*NREQ-1:0] req_radius = '0;
   logic [2*NREQ-1:0] req_mode = '0;
   logic              set_en;
   logic [23:0]       set_central;
   logic [11:0]       set_radius;
   logic [1:0]        set_mode;
   logic              set_busy = 1'b0;
   logic              set_valid = 1'b0;
   logic [7:0]        set_candidate = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [IDW-1:0]    rsp_id;
   logic [7:0]        rsp_candidate;
   logic              rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   set_job_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYC(80)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_central(req_central), .req_radius(req_radius), .req_mode(req_mode),
      .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
      .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_candidate(rsp_candidate), .rsp_err(rsp_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic set_payload(input int i, input logic [23:0] c, input logic [11:0] r,
                              input logic [1:0] m);
      req_central[24*i +: 24] = c;
      req_radius[12*i +: 12]  = r;
      req_mode[2*i +: 2]      = m;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req_valid = 4'b1000;
      step();
      step();
      mid();
      n_tests++;
      if (req_ready !== 4'b0000) begin
         n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
      end
      n_tests++;
      if ({set_en, rsp_valid} !== 2'b00) begin
         n_fail++; $display("FAIL reset_strobes: got set_en=%b rsp_valid=%b want 0 0", set_en, rsp_valid);
      end
      n_tests++;
      if ({set_central, set_radius, set_mode} !== 38'd0) begin
         n_fail++; $display("FAIL reset_set_payload: got %h %h %h want 0", set_central, set_radius, set_mode);
      end
      n_tests++;
      if ({rsp_id, rsp_candidate, rsp_err} !== 11'd0) begin
         n_fail++; $display("FAIL reset_rsp: got id=%0d cand=%0d err=%b want 0", rsp_id, rsp_candidate, rsp_err);
      end
      step();
      rst = 1'b1;
      req_valid = '0;
   endtask

   task automatic test_single();
      int en_cnt = 0;
      step();
      set_payload(1, 24'h440000, 12'h200, 2'd0);
      req_valid = 4'b0010;
      mid();
      n_tests++;
      if (req_ready !== 4'b0010) begin
         n_fail++; $display("FAIL single_ready: got %b want 0010", req_ready);
      end
      step();
      req_valid = '0;
      mid();
      en_cnt += int'(set_en);
      n_tests++;
      if ({set_central, set_radius, set_mode} !== {24'h440000, 12'h200, 2'd0}) begin
         n_fail++; $display("FAIL single_payload: got %h %h %h want 440000 200 0", set_central, set_radius, set_mode);
      end
      step();
      set_valid = 1'b1;
      set_candidate = 8'd13;
      mid();
      en_cnt += int'(set_en);
      step();
      set_valid = 1'b0;
      set_candidate = '0;
      mid();
      en_cnt += int'(set_en);
      n_tests++;
      if ({rsp_valid, rsp_id, rsp_candidate, rsp_err} !== {1'b1, 2'd1, 8'd13, 1'b0}) begin
         n_fail++; $display("FAIL single_rsp: got v=%b id=%0d cand=%0d err=%b want 1 1 13 0", rsp_valid, rsp_id, rsp_candidate, rsp_err);
      end
      step();
      rsp_ready = 1'b1;
      mid();
      en_cnt += int'(set_en);
      step();
      rsp_ready = 1'b0;
      mid();
      en_cnt += int'(set_en);
      n_tests++;
      if (rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_rsp_clear: got %b want 0", rsp_valid);
      end
      n_tests++;
      if (en_cnt !== 1) begin
         n_fail++; $display("FAIL single_en_pulses: got %0d want 1", en_cnt);
      end
   endtask

   task automatic test_round_robin();
      int exp_order[6] = '{0, 1, 2, 3, 0, 1};
      int grants[6] = '{-1, -1, -1, -1, -1, -1};
      int n_grant = 0;
      int rsp_n = 0;
      int rr_since = 0;
      logic pend = 1'b0;
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) set_payload(i, 24'(i + 1), 12'(i + 1), 2'(i));
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && rsp_n < 6; cyc++) begin
         mid();
         if (req_ready != '0) begin
            rr_since++;
            for (int j = 0; j < 4; j++) begin
               if (req_ready[j] && n_grant < 6) grants[n_grant] = j;
            end
            n_grant++;
         end
         if (set_en) begin
            n_tests++;
            if (rr_since !== 1) begin
               n_fail++; $display("FAIL rr_ready_pulses: got %0d before set_en want 1", rr_since);
            end
            rr_since = 0;
            pend = 1'b1;
         end
         if (rsp_valid) begin
            n_tests++;
            if (rsp_n < 6 && 32'(rsp_id) !== exp_order[rsp_n]) begin
               n_fail++; $display("FAIL rr_rsp_id[%0d]: got %0d want %0d", rsp_n, rsp_id, exp_order[rsp_n]);
            end
            rsp_n++;
         end
         step();
         set_valid = pend;
         pend = 1'b0;
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      n_tests++;
      if (rsp_n !== 6) begin
         n_fail++; $display("FAIL rr_responses: got %0d want 6", rsp_n);
      end
      for (int i = 0; i < 6; i++) begin
         n_tests++;
         if (grants[i] !== exp_order[i]) begin
            n_fail++; $display("FAIL rr_grant[%0d]: got %0d want %0d", i, grants[i], exp_order[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      step();
      set_payload(2, 24'h123456, 12'hABC, 2'd2);
      set_payload(3, 24'h654321, 12'h321, 2'd3);
      req_valid = 4'b1100;
      rsp_ready = 1'b0;
      mid();
      n_tests++;
      if (req_ready !== 4'b0100) begin
         n_fail++; $display("FAIL bp_ready: got %b want 0100", req_ready);
      end
      step();
      req_valid = 4'b1000;
      step();
      step();
      set_valid = 1'b1;
      set_candidate = 8'h5A;
      step();
      set_valid = 1'b0;
      set_candidate = '0;
      for (int i = 0; i < 10; i++) begin
         mid();
         n_tests++;
         if ({rsp_valid, rsp_id, rsp_candidate, rsp_err, req_ready, set_en} !==
             {1'b1, 2'd2, 8'h5A, 1'b0, 4'b0000, 1'b0}) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d cand=%h err=%b rdy=%b en=%b want 1 2 5a 0 0000 0", i, rsp_valid, rsp_id, rsp_candidate, rsp_err, req_ready, set_en);
         end
         step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      mid();
      n_tests++;
      if ({rsp_valid, req_ready} !== {1'b0, 4'b1000}) begin
         n_fail++; $display("FAIL bp_next_grant: got v=%b rdy=%b want 0 1000", rsp_valid, req_ready);
      end
   endtask

   task automatic test_busy();
      for (int i = 0; i < 5; i++) begin
         step();
         if (i == 0) begin set_busy = 1'b1; req_valid = '0; end
         if (i == 2) begin set_valid = 1'b1; set_candidate = 8'd99; end
         if (i == 3) begin set_valid = 1'b0; set_candidate = '0; end
         mid();
         n_tests++;
         if ({set_en, rsp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL busy_hold[%0d]: got en=%b v=%b want 0 0", i, set_en, rsp_valid);
         end
      end
      step();
      set_busy = 1'b0;
      mid();
      n_tests++;
      if ({set_en, set_central, set_radius, set_mode} !== {1'b1, 24'h654321, 12'h321, 2'd3}) begin
         n_fail++; $display("FAIL busy_release: got en=%b %h %h %h want 1 654321 321 3", set_en, set_central, set_radius, set_mode);
      end
      step();
      set_valid = 1'b1;
      set_candidate = 8'd77;
      step();
      set_valid = 1'b0;
      set_candidate = '0;
      mid();
      n_tests++;
      if ({rsp_valid, rsp_id, rsp_candidate, rsp_err} !== {1'b1, 2'd3, 8'd77, 1'b0}) begin
         n_fail++; $display("FAIL busy_rsp: got v=%b id=%0d cand=%0d err=%b want 1 3 77 0", rsp_valid, rsp_id, rsp_candidate, rsp_err);
      end
      step();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      step();
      req_valid = 4'b0100;
      mid();
      n_tests++;
      if (req_ready !== 4'b0100) begin
         n_fail++; $display("FAIL rmid_ready: got %b want 0100", req_ready);
      end
      step();
      req_valid = '0;
      step();
      rst = 1'b0;
      set_payload(0, 24'hA5A5A5, 12'h5A5, 2'd1);
      req_valid = 4'b1001;
      step();
      mid();
      n_tests++;
      if ({req_ready, set_en, rsp_valid, rsp_id, rsp_candidate, rsp_err} !== 17'd0) begin
         n_fail++; $display("FAIL rmid_outputs: got rdy=%b en=%b v=%b id=%0d cand=%0d err=%b want 0", req_ready, set_en, rsp_valid, rsp_id, rsp_candidate, rsp_err);
      end
      n_tests++;
      if ({set_central, set_radius, set_mode} !== 38'd0) begin
         n_fail++; $display("FAIL rmid_payload: got %h %h %h want 0", set_central, set_radius, set_mode);
      end
      step();
      rst = 1'b1;
      mid();
      n_tests++;
      if (req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL rmid_first_grant: got %b want 0001", req_ready);
      end
      step();
      req_valid = '0;
      mid();
      n_tests++;
      if ({set_en, set_central} !== {1'b1, 24'hA5A5A5}) begin
         n_fail++; $display("FAIL rmid_issue: got en=%b central=%h want 1 a5a5a5", set_en, set_central);
      end
      step();
      set_valid = 1'b1;
      set_candidate = 8'h11;
      step();
      set_valid = 1'b0;
      set_candidate = '0;
      mid();
      n_tests++;
      if ({rsp_valid, rsp_id, rsp_candidate} !== {1'b1, 2'd0, 8'h11}) begin
         n_fail++; $display("FAIL rmid_rsp: got v=%b id=%0d cand=%h want 1 0 11", rsp_valid, rsp_id, rsp_candidate);
      end
      step();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

`ifdef SET_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int rise = -1;
      req_valid = 4'b0010;
      mid();
      step();
      req_valid = '0;
      mid();
      n_tests++;
      if (set_en !== 1'b1) begin
         n_fail++; $display("FAIL to_issue: got set_en=%b want 1", set_en);
      end
      for (int k = 1; k <= 100; k++) begin
         step();
         mid();
         if (rsp_valid) begin rise = k; break; end
      end
      n_tests++;
      if (rise !== 81) begin
         n_fail++; $display("FAIL to_abort_cycle: got %0d want 81", rise);
      end
      n_tests++;
      if ({rsp_id, rsp_candidate, rsp_err} !== {2'd1, 8'd0, 1'b1}) begin
         n_fail++; $display("FAIL to_abort_rsp: got id=%0d cand=%0d err=%b want 1 0 1", rsp_id, rsp_candidate, rsp_err);
      end
      step();
      set_valid = 1'b1;
      set_candidate = 8'd55;
      step();
      set_valid = 1'b0;
      set_candidate = '0;
      mid();
      n_tests++;
      if ({rsp_valid, rsp_candidate, rsp_err} !== {1'b1, 8'd0, 1'b1}) begin
         n_fail++; $display("FAIL to_late_valid: got v=%b cand=%0d err=%b want 1 0 1", rsp_valid, rsp_candidate, rsp_err);
      end
      step();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      req_valid = 4'b0100;
      mid();
      step();
      req_valid = '0;
      rise = -1;
      for (int k = 1; k <= 100; k++) begin
         step();
         set_valid = (k == 80);
         set_candidate = (k == 80) ? 8'd42 : 8'd0;
         mid();
         if (rsp_valid) begin rise = k; break; end
      end
      set_valid = 1'b0;
      set_candidate = '0;
      n_tests++;
      if (rise !== 81) begin
         n_fail++; $display("FAIL to_race_cycle: got %0d want 81", rise);
      end
      n_tests++;
      if ({rsp_id, rsp_candidate, rsp_err} !== {2'd2, 8'd42, 1'b0}) begin
         n_fail++; $display("FAIL to_race_rsp: got id=%0d cand=%0d err=%b want 2 42 0", rsp_id, rsp_candidate, rsp_err);
      end
      step();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_busy();
      test_reset_mid();
`ifdef SET_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/set_job_arbiter.md
Name: set_job_arbiter

Overview:
- Sits in front of one SET circle-candidate counting engine and shares it between NREQ requesters.
- Accepts jobs (central, radius, mode) and grants them round-robin.
- Issues each granted job to the engine with a one-cycle set_en, waits for set_valid, and returns the candidate count tagged with the requester id.
- Only one job is in flight at a time; the result is held until the consumer accepts it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester id (clog2(NREQ)).
- TIMEOUT_CYC, 80, maximum WAIT cycles before abort (used only with SET_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester job valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_central  in  24*NREQ  requester i occupies bits [24i+23:24i]; {x0,y0,x1,y1,x2,y2}, 4 bits each.
- req_radius  in  12*NREQ  requester i occupies bits [12i+11:12i]; {r0,r1,r2}.
- req_mode  in  2*NREQ  requester i occupies bits [2i+1:2i].
- set_en  out  1  one-cycle job start to the engine.
- set_central  out  24  latched job centres.
- set_radius  out  12  latched job radii.
- set_mode  out  2  latched job mode.
- set_busy  in  1  engine busy.
- set_valid  in  1  engine result strobe.
- set_candidate  in  8  engine result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  id of the requester that owns the response.
- rsp_candidate  out  8  returned count.
- rsp_err  out  1  job aborted by timeout.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; last_grant=NREQ-1, so requester 0 has first priority.
  - All outputs 0: req_ready, set_en, set_central, set_radius, set_mode, rsp_valid, rsp_id, rsp_candidate, rsp_err.
  - Reset mid-job abandons the job with no response; the engine must be reset alongside.
- IDLE:
  - Winner g = first i with req_valid[i]=1, searching last_grant+1, last_grant+2, ... modulo NREQ.
  - req_ready[g] is driven combinationally in IDLE only; all other req_ready bits are 0.
  - On req_valid[g]&req_ready[g]: latch the payload into set_central/set_radius/set_mode, latch g into rsp_id, set last_grant=g, go to ISSUE.
  - No requests -> stay in IDLE.
- ISSUE:
  - If set_busy=0: set_en=1 for exactly this cycle, then go to WAIT.
  - If set_busy=1: hold set_en=0 and stay in ISSUE.
- WAIT:
  - On set_valid=1: rsp_candidate<=set_candidate, rsp_err<=0, rsp_valid<=1, go to RESP.
  - set_valid while not in WAIT is ignored.
- RESP:
  - rsp_valid, rsp_id, rsp_candidate and rsp_err are held stable while rsp_ready=0.
  - On rsp_valid&rsp_ready: rsp_valid<=0, go to IDLE.
  - No new grant occurs before the next IDLE cycle, so minimum spacing between grants is 1 IDLE cycle after the response handshake.
- Latency: grant -> set_en is 1 cycle when the engine is idle; set_valid -> rsp_valid is 1 cycle.
- Requesters must hold payload stable while req_valid=1. Dropping req_valid without a handshake is allowed; that requester simply loses its turn.
- set_central, set_radius and set_mode keep their latched value until the next grant.

Optional Feature:
- SET_ARB_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC with set_valid=0: rsp_candidate<=0, rsp_err<=1, rsp_valid<=1, go to RESP.
  - If set_valid=1 in the same cycle as the terminal count, set_valid wins (normal result, err=0).
  - A late set_valid arriving after the abort is ignored.
- SET_ARB_TIMEOUT_EN undefined:
  - No counter; WAIT lasts until set_valid; rsp_err is tied to 0.

Test Plan:
- Single job, requester 1: mode 0, central x0=4, y0=4, radius r0=2 -> exactly one set_en pulse, rsp_id=1, rsp_candidate=13, rsp_err=0.
- All 4 requesters held valid, rsp_ready=1 -> grant order 0,1,2,3,0,1; each set_en preceded by a single req_ready pulse.
- Hold rsp_ready=0 for 10 cycles after rsp_valid -> response fields stable, req_ready stays 0 and set_en stays 0 until the handshake, then the next grant follows.
- Force set_busy=1 for 5 cycles in ISSUE -> set_en held at 0 and asserted in the first cycle set_busy=0.
- SET_ARB_TIMEOUT_EN defined, engine never asserts set_valid -> rsp_valid rises after 80 WAIT cycles with rsp_err=1, rsp_candidate=0. A second run asserts set_valid exactly at the terminal count -> err=0 with the real count.
- rst=0 during WAIT, then release -> all outputs 0 and state IDLE; requester 0 is granted first even if requester 3 is also valid.
